// File: rtl/synth_pkg.sv
// ============================================================================
// Module   : synth_pkg
// Purpose  : Shared register field layout, FSM state types and accumulator
//            width helper for the synth_bank voice control / mixer block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package synth_pkg;

    localparam int CFG_BIT    = 31;
    localparam int TUNE_LSB   = 24;
    localparam int ATTACK_LSB = 16;
    localparam int DECAY_LSB  = 8;
    localparam int NOTE_LSB   = 1;
    localparam int GATE_BIT   = 0;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_ACK  = 2'd1,
        BUS_WAIT = 2'd2
    } bus_state_e;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_ACC  = 2'd1,
        M_OUT  = 2'd2
    } mix_state_e;

    function automatic int acc_width(input int bitdepth, input int nvoices);
        return bitdepth + $clog2(nvoices);
    endfunction

endpackage

`default_nettype wire

// File: rtl/synth_mixer.sv
// ============================================================================
// Module   : synth_mixer
// Purpose  : Snapshots all voice samples on each tick and sums them serially,
//            one voice per cycle, into a single PCM sample. Output scaling is
//            a clamp when SYNTH_MIX_SATURATE_EN is defined, else a shift.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module synth_mixer
    import synth_pkg::*;
#(
    parameter int NVOICES  = 8,
    parameter int BITDEPTH = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_tick,
    input  logic [BITDEPTH*NVOICES-1:0]   voice_pcm,
    output logic [BITDEPTH-1:0]           pcm,
    output logic                          pcm_valid
);

    localparam int ACC_W = acc_width(BITDEPTH, NVOICES);
    localparam int SHIFT = $clog2(NVOICES);
    localparam int IDX_W = SHIFT;

`ifdef SYNTH_MIX_SATURATE_EN
    localparam logic signed [ACC_W-1:0] PCM_MAX =
        {{(ACC_W-BITDEPTH+1){1'b0}}, {(BITDEPTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] PCM_MIN =
        {{(ACC_W-BITDEPTH+1){1'b1}}, {(BITDEPTH-1){1'b0}}};
`endif

    mix_state_e                  state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic signed [ACC_W-1:0]     sum;
    logic [BITDEPTH-1:0]         scaled;
    logic [BITDEPTH-1:0]         pcm_q, pcm_d;
    logic [BITDEPTH-1:0]         snap_q [NVOICES];
    logic [BITDEPTH-1:0]         snap_d [NVOICES];

    always_comb begin
        sum = acc_q + {{(ACC_W-BITDEPTH){snap_q[idx_q][BITDEPTH-1]}}, snap_q[idx_q]};
`ifdef SYNTH_MIX_SATURATE_EN
        if (sum > PCM_MAX) begin
            scaled = PCM_MAX[BITDEPTH-1:0];
        end else if (sum < PCM_MIN) begin
            scaled = PCM_MIN[BITDEPTH-1:0];
        end else begin
            scaled = sum[BITDEPTH-1:0];
        end
`else
        // Sign bit sits at ACC_W-1 = SHIFT+BITDEPTH-1, so this slice is sum >>> SHIFT
        scaled = sum[SHIFT +: BITDEPTH];
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        pcm_d   = pcm_q;
        snap_d  = snap_q;
        case (state_q)
            M_IDLE: begin
                if (sample_tick) begin
                    for (int i = 0; i < NVOICES; i++) begin
                        snap_d[i] = voice_pcm[BITDEPTH*i +: BITDEPTH];
                    end
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = M_ACC;
                end
            end
            M_ACC: begin
                acc_d = sum;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(NVOICES-1)) begin
                    idx_d   = '0;
                    pcm_d   = scaled;
                    state_d = M_OUT;
                end
            end
            M_OUT: begin
                state_d = M_IDLE;
            end
            default: begin
                state_d = M_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= M_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            pcm_q   <= '0;
            for (int i = 0; i < NVOICES; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            pcm_q   <= pcm_d;
            snap_q  <= snap_d;
        end
    end

    assign pcm       = pcm_q;
    assign pcm_valid = (state_q == M_OUT);

endmodule

`default_nettype wire

// File: rtl/synth_bank.sv
// ============================================================================
// Module   : synth_bank
// Purpose  : Per-voice CPU control registers, bus handshake FSM, sample-tick
//            generator and voice mixer. Option macro: SYNTH_MIX_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module synth_bank
    import synth_pkg::*;
#(
    parameter int NVOICES         = 8,
    parameter int ADDR_W          = 4,
    parameter int BITDEPTH        = 14,
    parameter int SAMPLECLOCK_DIV = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [31:0]                   data_in,
    input  logic                          wen,
    input  logic                          ren,
    output logic                          ready,
    output logic [31:0]                   data_out,
    output logic                          sample_tick,
    output logic [7*NVOICES-1:0]          v_note,
    output logic [NVOICES-1:0]            v_gate,
    output logic [7*NVOICES-1:0]          v_tuning,
    output logic [8*NVOICES-1:0]          v_attack,
    output logic [8*NVOICES-1:0]          v_decay,
    input  logic [BITDEPTH*NVOICES-1:0]   voice_pcm,
    output logic [BITDEPTH-1:0]           pcm,
    output logic                          pcm_valid
);

    bus_state_e                  bus_state_q, bus_state_d;
    logic [31:0]                 data_out_q, data_out_d;
    logic [SAMPLECLOCK_DIV-1:0]  tick_cnt_q, tick_cnt_d;
    logic [6:0]                  note_q   [NVOICES];
    logic [6:0]                  note_d   [NVOICES];
    logic                        gate_q   [NVOICES];
    logic                        gate_d   [NVOICES];
    logic [6:0]                  tuning_q [NVOICES];
    logic [6:0]                  tuning_d [NVOICES];
    logic [7:0]                  attack_q [NVOICES];
    logic [7:0]                  attack_d [NVOICES];
    logic [7:0]                  decay_q  [NVOICES];
    logic [7:0]                  decay_d  [NVOICES];

    // Read data is captured before the write lands, so a combined request returns the old word
    always_comb begin
        bus_state_d = bus_state_q;
        data_out_d  = data_out_q;
        note_d      = note_q;
        gate_d      = gate_q;
        tuning_d    = tuning_q;
        attack_d    = attack_q;
        decay_d     = decay_q;
        tick_cnt_d  = tick_cnt_q + 1'b1;
        case (bus_state_q)
            BUS_IDLE: begin
                if (wen || ren) begin
                    bus_state_d = BUS_ACK;
                    data_out_d  = 32'd0;
                    for (int i = 0; i < NVOICES; i++) begin
                        if (addr == ADDR_W'(i)) begin
                            data_out_d = {1'b0, tuning_q[i], attack_q[i], decay_q[i],
                                          note_q[i], gate_q[i]};
                            if (wen) begin
                                note_d[i] = data_in[NOTE_LSB +: 7];
                                gate_d[i] = data_in[GATE_BIT];
                                if (data_in[CFG_BIT]) begin
                                    tuning_d[i] = data_in[TUNE_LSB +: 7];
                                    attack_d[i] = data_in[ATTACK_LSB +: 8];
                                    decay_d[i]  = data_in[DECAY_LSB +: 8];
                                end
                            end
                        end
                    end
                end
            end
            BUS_ACK: begin
                bus_state_d = BUS_WAIT;
            end
            BUS_WAIT: begin
                if (!(wen || ren)) begin
                    bus_state_d = BUS_IDLE;
                end
            end
            default: begin
                bus_state_d = BUS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_state_q <= BUS_IDLE;
            data_out_q  <= '0;
            tick_cnt_q  <= '0;
            for (int i = 0; i < NVOICES; i++) begin
                note_q[i]   <= '0;
                gate_q[i]   <= 1'b0;
                tuning_q[i] <= '0;
                attack_q[i] <= '0;
                decay_q[i]  <= '0;
            end
        end else begin
            bus_state_q <= bus_state_d;
            data_out_q  <= data_out_d;
            tick_cnt_q  <= tick_cnt_d;
            note_q      <= note_d;
            gate_q      <= gate_d;
            tuning_q    <= tuning_d;
            attack_q    <= attack_d;
            decay_q     <= decay_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NVOICES; gi++) begin : g_voice_out
            assign v_note[7*gi +: 7]   = note_q[gi];
            assign v_gate[gi]          = gate_q[gi];
            assign v_tuning[7*gi +: 7] = tuning_q[gi];
            assign v_attack[8*gi +: 8] = attack_q[gi];
            assign v_decay[8*gi +: 8]  = decay_q[gi];
        end
    endgenerate

    assign ready       = (bus_state_q == BUS_ACK);
    assign data_out    = data_out_q;
    assign sample_tick = &tick_cnt_q;

    synth_mixer #(
        .NVOICES  (NVOICES),
        .BITDEPTH (BITDEPTH)
    ) u_mixer (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .voice_pcm   (voice_pcm),
        .pcm         (pcm),
        .pcm_valid   (pcm_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_synth_bank.sv
// ============================================================================
// Module   : tb_synth_bank
// Purpose  : Scoreboard bench for synth_bank: randomized bus traffic and voice
//            samples checked against a behavioural register/mix model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_synth_bank;

    localparam int NV  = 8;
    localparam int AW  = 4;
    localparam int BD  = 14;
    localparam int DIV = 8;

    typedef struct {
        int val;
        int cyc;
    } pexp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [AW-1:0]        addr = '0;
    logic [31:0]          data_in = '0;
    logic                 wen = 1'b0;
    logic                 ren = 1'b0;
    logic                 ready;
    logic [31:0]          data_out;
    logic                 sample_tick;
    logic [7*NV-1:0]      v_note;
    logic [NV-1:0]        v_gate;
    logic [7*NV-1:0]      v_tuning;
    logic [8*NV-1:0]      v_attack;
    logic [8*NV-1:0]      v_decay;
    logic [BD*NV-1:0]     voice_pcm = '0;
    logic [BD-1:0]        pcm;
    logic                 pcm_valid;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          rel_cyc  = 0;
    int          last_tick = -1;
    int          mode     = 0;
    logic [31:0] regs [NV];
    logic [31:0] bus_q [$];
    pexp_t       pcm_q [$];
    int          vec [NV] = '{1, 25, -50, 100, 0, 0, 0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    synth_bank #(
        .NVOICES         (NV),
        .ADDR_W          (AW),
        .BITDEPTH        (BD),
        .SAMPLECLOCK_DIV (DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .data_in     (data_in),
        .wen         (wen),
        .ren         (ren),
        .ready       (ready),
        .data_out    (data_out),
        .sample_tick (sample_tick),
        .v_note      (v_note),
        .v_gate      (v_gate),
        .v_tuning    (v_tuning),
        .v_attack    (v_attack),
        .v_decay     (v_decay),
        .voice_pcm   (voice_pcm),
        .pcm         (pcm),
        .pcm_valid   (pcm_valid)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Mixed output: total of all voices, then either clamped or floor-divided by 2**clog2(NV)
    function automatic int ref_mix(input int s);
        int d;
        d = 1 << $clog2(NV);
`ifdef SYNTH_MIX_SATURATE_EN
        if (s > (1 << (BD-1)) - 1) return (1 << (BD-1)) - 1;
        if (s < -(1 << (BD-1)))    return -(1 << (BD-1));
        return s;
`else
        if (s < 0 && (s % d) != 0) return s / d - 1;
        return s / d;
`endif
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d);
        if (a < NV) begin
            if (d[31]) regs[a] = {1'b0, d[30:0]};
            else       regs[a][7:0] = d[7:0];
        end
    endtask

    task automatic check_voices(input string tag);
        logic [7*NV-1:0] en, et;
        logic [8*NV-1:0] ea, ed;
        logic [NV-1:0]   eg;
        for (int i = 0; i < NV; i++) begin
            en[7*i +: 7] = regs[i][7:1];
            eg[i]        = regs[i][0];
            ed[8*i +: 8] = regs[i][15:8];
            ea[8*i +: 8] = regs[i][23:16];
            et[7*i +: 7] = regs[i][30:24];
        end
        chk({tag, "_v_note"},   64'(v_note),   64'(en));
        chk({tag, "_v_gate"},   64'(v_gate),   64'(eg));
        chk({tag, "_v_tuning"}, 64'(v_tuning), 64'(et));
        chk({tag, "_v_attack"}, 64'(v_attack), 64'(ea));
        chk({tag, "_v_decay"},  64'(v_decay),  64'(ed));
    endtask

    task automatic bus_op(input bit w, input bit r, input logic [AW-1:0] a,
                          input logic [31:0] d, input int hold);
        @(negedge clk);
        wen = w; ren = r; addr = a; data_in = d;
        bus_q.push_back((a < NV) ? regs[a] : 32'd0);
        if (w) model_write(a, d);
        @(posedge clk); #1;
        chk("ready_latency", 64'(ready), 64'd1);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        wen = 1'b0; ren = 1'b0;
        @(negedge clk);
        check_voices("bus");
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_tick && n < 600);
        if (!sample_tick) chk("tick_timeout", 64'd0, 64'd1);
    endtask

    // Voice sample driver: new samples each cycle; on a tick the value just driven is what gets mixed
    initial begin : voice_drv
        int s;
        logic signed [BD-1:0] v;
        forever begin
            @(negedge clk);
            s = 0;
            for (int i = 0; i < NV; i++) begin
                case (mode)
                    0:       v = BD'($urandom);
                    1:       v = BD'(8191);
                    2:       v = BD'(-8192);
                    default: v = BD'(vec[i]);
                endcase
                voice_pcm[BD*i +: BD] = v;
                s += v;
            end
            if (sample_tick && !rst) pcm_q.push_back('{ref_mix(s), cyc});
        end
    end

    initial begin : monitor
        pexp_t e;
        forever begin
            @(negedge clk);
            if (ready) begin
                if (bus_q.size() == 0) chk("ready_unexpected", 64'd1, 64'd0);
                else chk("read_data", 64'(data_out), 64'(bus_q.pop_front()));
            end
            if (pcm_valid) begin
                if (pcm_q.size() == 0) chk("pcm_valid_unexpected", 64'd1, 64'd0);
                else begin
                    e = pcm_q.pop_front();
                    chk("pcm_value", 64'(longint'($signed(pcm))), 64'(longint'(e.val)));
                    chk("pcm_latency", 64'(cyc), 64'(e.cyc + NV + 1));
                end
            end
        end
    end

    initial begin : tick_mon
        forever begin
            @(negedge clk);
            if (!rst && sample_tick) begin
                if (last_tick < 0) chk("tick_first", 64'(cyc - rel_cyc), 64'd255);
                else               chk("tick_period", 64'(cyc - last_tick), 64'd256);
                last_tick = cyc;
            end
        end
    end

    initial begin : main
        logic [AW-1:0] a;
        int            k;
        for (int i = 0; i < NV; i++) regs[i] = '0;
        repeat (4) @(negedge clk);
        chk("rst_ctrl", 64'({ready, sample_tick, pcm_valid, pcm}), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        check_voices("rst");
        rst = 1'b0;
        rel_cyc = cyc;
        last_tick = -1;

        bus_op(1'b1, 1'b0, 4'd2, 32'h80F0_4079, 0);
        chk("note2_is_60", 64'(v_note[20:14]), 64'd60);
        chk("gate2_set", 64'(v_gate[2]), 64'd1);
        bus_op(1'b0, 1'b1, 4'd2, 32'h0, 0);
        bus_op(1'b1, 1'b0, 4'd2, 32'h0000_0040, 0);
        bus_op(1'b0, 1'b1, 4'd2, 32'h0, 0);
        bus_op(1'b1, 1'b0, 4'd15, 32'hFFFF_FFFF, 0);
        bus_op(1'b0, 1'b1, 4'd15, 32'h0, 0);
        bus_op(1'b1, 1'b0, 4'd3, 32'h8123_4567, 4);
        bus_op(1'b1, 1'b1, 4'd3, 32'h8765_4321, 0);
        bus_op(1'b0, 1'b1, 4'd3, 32'h0, 0);
        for (int n = 0; n < 16; n++) begin
            a = AW'($urandom_range(0, 15));
            k = $urandom_range(0, 2);
            bus_op(k != 1, k != 0, a, $urandom, $urandom_range(0, 2));
        end

        repeat (2) wait_tick();
        mode = 1;
        wait_tick();
        mode = 2;
        wait_tick();
        mode = 3;
        wait_tick();
        mode = 0;
        wait_tick();
        repeat (NV + 3) @(negedge clk);

        wait_tick();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pcm_q.delete();
        for (int i = 0; i < NV; i++) regs[i] = '0;
        @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
        last_tick = -1;
        chk("abort_pcm_zero", 64'(pcm), 64'd0);
        check_voices("abort");
        repeat (NV + 4) @(negedge clk);
        chk("abort_pcm_hold", 64'(pcm), 64'd0);

        wait_tick();
        repeat (NV + 3) @(negedge clk);
        chk("bus_queue_empty", 64'(bus_q.size()), 64'd0);
        chk("pcm_queue_empty", 64'(pcm_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/synth_bank.md
# synth_bank

Parametrised multi-voice control and mixing front end for the audio synth peripheral. It holds one CPU-writable control register per voice and exposes the decoded fields to the voice oscillators. It generates a single-clock sample-tick strobe and mixes the voices' PCM outputs into one sample per tick for the DAC. It sits between the CPU bus and the voice/DAC chain, replacing the single fixed voice with N configurable voices.

## Interface
- `NVOICES`, 8: number of voices, 2..16.
- `ADDR_W`, 4: CPU address width; must satisfy 2**ADDR_W ≥ NVOICES.
- `BITDEPTH`, 14: signed PCM sample width.
- `SAMPLECLOCK_DIV`, 8: tick period is 2**SAMPLECLOCK_DIV clk cycles; must exceed NVOICES+3.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `addr` in ADDR_W: voice register select.
- `data_in` in 32: write data.
- `wen` in 1: write request, held until `ready`.
- `ren` in 1: read request, held until `ready`.
- `ready` out 1: one-cycle request acknowledge.
- `data_out` out 32: read data, valid while `ready` is high.
- `sample_tick` out 1: one-clk strobe, once per sample period.
- `v_note` out 7*NVOICES: per-voice note, voice i at bits [7i+6:7i].
- `v_gate` out NVOICES: per-voice gate.
- `v_tuning` out 7*NVOICES: per-voice tuning.
- `v_attack` out 8*NVOICES: per-voice attack rate.
- `v_decay` out 8*NVOICES: per-voice decay rate.
- `voice_pcm` in BITDEPTH*NVOICES: signed voice outputs, voice i at bits [BITDEPTH*i+BITDEPTH-1:BITDEPTH*i].
- `pcm` out BITDEPTH: mixed signed sample to the DAC.
- `pcm_valid` out 1: one-clk strobe when `pcm` updates.

## Operation
- Register word layout: [31] config flag, [30:24] tuning, [23:16] attack, [15:8] decay, [7:1] note, [0] gate.
- Write commits in the first cycle `wen` is seen with the bus FSM in IDLE.
  - Config flag = 1: all fields are updated.
  - Config flag = 0: only note and gate are updated; tuning, attack and decay keep their values.
  - Stored bit 31 always reads back as 0.
- Read: `data_out` = {1'b0, tuning, attack, decay, note, gate} of the addressed voice.
- Address ≥ NVOICES: the write is ignored, a read returns 0, and `ready` is still given.
- `wen` and `ren` asserted together: treated as a write; `data_out` returns the pre-write value.
- Bus FSM:
  - IDLE → ACK on `wen|ren`.
  - ACK: `ready`=1 for exactly one cycle → WAIT.
  - WAIT → IDLE once `wen|ren` is deasserted.
  - A request held high therefore yields one `ready` and one commit.
- Tick counter: free-running SAMPLECLOCK_DIV-bit counter; `sample_tick`=1 in the cycle the counter equals all-ones.
- Mixer FSM:
  - M_IDLE: on `sample_tick`, snapshot all of `voice_pcm` into registers and clear the accumulator → M_ACC.
  - M_ACC: add snapshot[i] (sign-extended) for i = 0..NVOICES-1, one per cycle → M_OUT.
  - M_OUT: load `pcm`, pulse `pcm_valid` → M_IDLE.
- Accumulator width is BITDEPTH + clog2(NVOICES), signed.
- Register writes during a mix do not affect the mix in progress, because it works from the snapshot.

## Timing
- Reset values: `ready` 0, `data_out` 0, `sample_tick` 0, `pcm` 0, `pcm_valid` 0, all voice fields 0, tick counter 0, both FSMs idle.
- First `sample_tick` occurs 2**SAMPLECLOCK_DIV−1 cycles after `rst` deasserts.
- Request seen in cycle t: commit at the t edge, `ready` in cycle t+1.
- Write-to-output latency: `v_*` outputs reflect the write in cycle t+1.
- `sample_tick` in cycle t: `pcm_valid` in cycle t+NVOICES+1.
- Reset mid-mix aborts the mix; no `pcm_valid` is produced and `pcm` returns to 0.
- Reset during ACK: `ready` drops to 0 in the next cycle.

## Configuration
- `SYNTH_MIX_SATURATE_EN`:
  - Defined: `pcm` = accumulator clamped to [−2**(BITDEPTH−1), 2**(BITDEPTH−1)−1].
  - Undefined: `pcm` = accumulator arithmetically shifted right by clog2(NVOICES), with no clamp.

## Structure
- Shared package `synth_pkg`:
  - Register field bit positions.
  - Bus FSM state type and mixer FSM state type.
  - Accumulator-width function.
- One sub-module, `synth_mixer`: snapshot, accumulator, FSM and saturation/scale logic.
- Register file, bus FSM and tick counter live in `synth_bank`.

## Test plan
- Write 0x80F0_4079 to addr 2, then read addr 2:
  - `ready` is one cycle after the request.
  - Read returns 0x00F0_4079.
  - `v_note[20:14]`=60 and `v_gate[2]`=1.
- Write 0x0000_0040 to addr 2:
  - Read returns 0x00F0_4040.
  - Attack and decay are unchanged, gate=0.
- With SAMPLECLOCK_DIV=8, hold `rst` then release:
  - Ticks occur exactly 256 cycles apart.
  - `pcm_valid` follows each tick by NVOICES+1 cycles.
- NVOICES=4, `voice_pcm` = {100, −50, 25, 1}:
  - `pcm`=76 with the macro defined.
  - `pcm`=19 without it.
- NVOICES=4, all voices 0x1FFF (BITDEPTH=14):
  - Macro defined: `pcm`=0x1FFF (saturated).
  - Macro undefined: `pcm`=0x1FFF from the shift.
- Remaining boundary cases:
  - Write to addr 15 with NVOICES=8: `ready` is given, no field changes.
  - Read addr 15: returns 0.
  - Assert `rst` two cycles after a tick: no `pcm_valid` and `pcm`=0.
